// File: rtl/uart_native_resp.sv
// rtl/uart_native_resp.sv - polled console UART responder (8N1) on the native bus; optional flow control via UART_RTS_CTS_EN
module uart_native_resp #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 3,
   parameter int DIV_W  = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                valid,
   input  logic [ADDR_W-1:0]   address,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W/8-1:0] wstrb,
   output logic [DATA_W-1:0]   rdata,
   output logic                ready,
   output logic                txd,
   input  logic                rxd
`ifdef UART_RTS_CTS_EN
   ,
   output logic                rts,
   input  logic                cts
`endif
);

   localparam logic [ADDR_W-1:0] A_SOFTRESET = ADDR_W'(0);
   localparam logic [ADDR_W-1:0] A_DIV       = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] A_TXDATA    = ADDR_W'(2);
   localparam logic [ADDR_W-1:0] A_TXEN      = ADDR_W'(3);
   localparam logic [ADDR_W-1:0] A_RXEN      = ADDR_W'(4);
   localparam logic [ADDR_W-1:0] A_TXREADY   = ADDR_W'(5);
   localparam logic [ADDR_W-1:0] A_RXREADY   = ADDR_W'(6);
   localparam logic [ADDR_W-1:0] A_RXDATA    = ADDR_W'(7);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   // bus side
   logic              ready_q;
   logic [DATA_W-1:0] rdata_q;
   logic [DATA_W-1:0] rd_mux;
   logic              bus_wr, bus_rd, soft_rst;

   // configuration
   logic [DIV_W-1:0]  div_q;
   logic [DIV_W-1:0]  div_eff;
   logic              txen_q, rxen_q;

   // transmit path
   state_t            tx_state_q, tx_state_d;
   logic [DIV_W-1:0]  tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
   logic [2:0]        tx_bit_q, tx_bit_d;
   logic [7:0]        tx_shift_q, tx_shift_d;
   logic              txd_q, txd_d;
   logic              tx_last, tx_ready, tx_go, cts_ok;

   // receive path
   state_t            rx_state_q, rx_state_d;
   logic [DIV_W-1:0]  rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
   logic [2:0]        rx_bit_q, rx_bit_d;
   logic [7:0]        rx_shift_q, rx_shift_d;
   logic [7:0]        rxdata_q, rxdata_d;
   logic              rxready_q, rxready_d;
   logic              rx_s1_q, rx_s2_q, rx_prev_q;
   logic              rx_fall, rx_hit;

   logic              unused_w;
   assign unused_w = ^wdata[DATA_W-1:DIV_W];

   assign bus_wr   = valid & (|wstrb);
   assign bus_rd   = valid & ~(|wstrb);
   assign soft_rst = bus_wr & (address == A_SOFTRESET) & wdata[0];

   // divisors below 2 would leave no room for a mid-bit sample
   assign div_eff = (div_q < DIV_W'(2)) ? DIV_W'(2) : div_q;

`ifdef UART_RTS_CTS_EN
   logic cts_s1_q, cts_s2_q;

   // cts crosses into clk through a two-flop synchronizer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cts_s1_q <= 1'b0;
         cts_s2_q <= 1'b0;
      end else begin
         cts_s1_q <= cts;
         cts_s2_q <= cts_s1_q;
      end
   end

   assign cts_ok = cts_s2_q;
   assign rts    = rxen_q & ~rxready_q;
`else
   assign cts_ok = 1'b1;
`endif

   assign tx_ready = txen_q & (tx_state_q == S_IDLE) & cts_ok;
   assign tx_go    = bus_wr & (address == A_TXDATA) & tx_ready;
   assign tx_last  = (tx_cnt_q == tx_div_q - DIV_W'(1));

   assign rx_fall  = rx_prev_q & ~rx_s2_q;
   assign rx_hit   = (rx_state_q == S_START) ? (rx_cnt_q == (rx_div_q >> 1) - DIV_W'(1))
                                             : (rx_cnt_q == rx_div_q - DIV_W'(1));

   // status/data read multiplexer; write-only addresses read as zero
   always_comb begin
      rd_mux = '0;
      case (address)
         A_TXREADY: rd_mux = DATA_W'(tx_ready);
         A_RXREADY: rd_mux = DATA_W'(rxready_q);
         A_RXDATA:  rd_mux = DATA_W'(rxdata_q);
         default:   rd_mux = '0;
      endcase
   end

   // transmit FSM next state: start bit, 8 data bits LSB first, stop bit
   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_div_d   = tx_div_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      txd_d      = txd_q;
      if (soft_rst || !txen_q) begin
         tx_state_d = S_IDLE;
         tx_cnt_d   = '0;
         txd_d      = 1'b1;
      end else begin
         case (tx_state_q)
            S_IDLE: begin
               txd_d = 1'b1;
               if (tx_go) begin
                  tx_state_d = S_START;
                  tx_cnt_d   = '0;
                  tx_bit_d   = '0;
                  tx_div_d   = div_eff;
                  tx_shift_d = wdata[7:0];
                  txd_d      = 1'b0;
               end
            end
            S_START: begin
               if (tx_last) begin
                  tx_state_d = S_DATA;
                  tx_cnt_d   = '0;
                  txd_d      = tx_shift_q[0];
               end else begin
                  tx_cnt_d = tx_cnt_q + DIV_W'(1);
               end
            end
            S_DATA: begin
               if (tx_last) begin
                  tx_cnt_d = '0;
                  if (tx_bit_q == 3'd7) begin
                     tx_state_d = S_STOP;
                     txd_d      = 1'b1;
                  end else begin
                     tx_bit_d   = tx_bit_q + 3'd1;
                     tx_shift_d = tx_shift_q >> 1;
                     txd_d      = tx_shift_q[1];
                  end
               end else begin
                  tx_cnt_d = tx_cnt_q + DIV_W'(1);
               end
            end
            default: begin
               if (tx_last) begin
                  tx_state_d = S_IDLE;
                  tx_cnt_d   = '0;
               end else begin
                  tx_cnt_d = tx_cnt_q + DIV_W'(1);
               end
            end
         endcase
      end
   end

   // receive FSM next state: mid-bit sampling, glitch rejection, framing check
   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_div_d   = rx_div_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rxdata_d   = rxdata_q;
      rxready_d  = rxready_q;
      // a completing byte later in this block wins over the read-clear
      if (bus_rd && (address == A_RXDATA)) rxready_d = 1'b0;
      if (soft_rst) begin
         rx_state_d = S_IDLE;
         rx_cnt_d   = '0;
         rxready_d  = 1'b0;
      end else if (!rxen_q) begin
         rx_state_d = S_IDLE;
         rx_cnt_d   = '0;
      end else begin
         case (rx_state_q)
            S_IDLE: begin
               if (rx_fall) begin
                  rx_state_d = S_START;
                  rx_cnt_d   = '0;
                  rx_div_d   = div_eff;
               end
            end
            S_START: begin
               if (rx_hit) begin
                  rx_cnt_d = '0;
                  rx_bit_d = '0;
                  rx_state_d = rx_s2_q ? S_IDLE : S_DATA;
               end else begin
                  rx_cnt_d = rx_cnt_q + DIV_W'(1);
               end
            end
            S_DATA: begin
               if (rx_hit) begin
                  rx_cnt_d   = '0;
                  rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                  if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
                  else                  rx_bit_d   = rx_bit_q + 3'd1;
               end else begin
                  rx_cnt_d = rx_cnt_q + DIV_W'(1);
               end
            end
            default: begin
               if (rx_hit) begin
                  rx_state_d = S_IDLE;
                  rx_cnt_d   = '0;
                  if (rx_s2_q) begin
                     rxdata_d  = rx_shift_q;
                     rxready_d = 1'b1;
                  end
               end else begin
                  rx_cnt_d = rx_cnt_q + DIV_W'(1);
               end
            end
         endcase
      end
   end

   // bus acknowledge, registered read data and configuration registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ready_q <= 1'b0;
         rdata_q <= '0;
         div_q   <= '0;
         txen_q  <= 1'b0;
         rxen_q  <= 1'b0;
      end else begin
         ready_q <= valid;
         rdata_q <= bus_rd ? rd_mux : '0;
         if (bus_wr) begin
            case (address)
               A_DIV:   div_q  <= wdata[DIV_W-1:0];
               A_TXEN:  txen_q <= wdata[0];
               A_RXEN:  rxen_q <= wdata[0];
               default: ;
            endcase
         end
      end
   end

   // datapath state registers, rxd synchronizer included
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_state_q <= S_IDLE;
         tx_cnt_q   <= '0;
         tx_div_q   <= DIV_W'(2);
         tx_bit_q   <= '0;
         tx_shift_q <= '0;
         txd_q      <= 1'b1;
         rx_state_q <= S_IDLE;
         rx_cnt_q   <= '0;
         rx_div_q   <= DIV_W'(2);
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
         rxdata_q   <= '0;
         rxready_q  <= 1'b0;
         rx_s1_q    <= 1'b1;
         rx_s2_q    <= 1'b1;
         rx_prev_q  <= 1'b1;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_div_q   <= tx_div_d;
         tx_bit_q   <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
         txd_q      <= txd_d;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_div_q   <= rx_div_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
         rxdata_q   <= rxdata_d;
         rxready_q  <= rxready_d;
         rx_s1_q    <= rxd;
         rx_s2_q    <= rx_s1_q;
         rx_prev_q  <= rx_s2_q;
      end
   end

   assign ready = ready_q;
   assign rdata = rdata_q;
   assign txd   = txd_q;

endmodule

// File: tb/tb_uart_native_resp.sv
// tb/tb_uart_native_resp.sv - scoreboard bench for uart_native_resp
module tb_uart_native_resp;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid;
   logic [2:0]  address;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic [31:0] rdata;
   logic        ready;
   logic        txd;
   logic        rxd;
   logic        rxd_drv;
   logic        loopback;
`ifdef UART_RTS_CTS_EN
   logic        rts;
   logic        cts;
`endif

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];
   string       tag_q[$];

   assign rxd = loopback ? txd : rxd_drv;

   always #5 clk = ~clk;

   uart_native_resp dut (
      .clk     (clk),
      .rst     (rst),
      .valid   (valid),
      .address (address),
      .wdata   (wdata),
      .wstrb   (wstrb),
      .rdata   (rdata),
      .ready   (ready),
      .txd     (txd),
      .rxd     (rxd)
`ifdef UART_RTS_CTS_EN
      ,
      .rts     (rts),
      .cts     (cts)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      @(negedge clk);
      valid = 1'b1; address = a; wdata = d; wstrb = 4'hF;
      @(posedge clk); #1;
      valid = 1'b0; wstrb = 4'h0;
   endtask

   task automatic bus_read(input string tag, input logic [2:0] a, input logic [31:0] e);
      int n;
      exp_q.push_back(e);
      tag_q.push_back(tag);
      @(negedge clk);
      valid = 1'b1; address = a; wstrb = 4'h0;
      @(posedge clk); #1;
      valid = 1'b0;
      n = 0;
      while (!ready && n < 4) begin
         @(posedge clk); #1;
         n++;
      end
      if (!ready) begin
         check({tag, "_timeout"}, 32'(ready), 32'd1);
         void'(exp_q.pop_front());
         void'(tag_q.pop_front());
      end else begin
         check({tag, "_lat"}, 32'(n), 32'd0);
         check(tag_q.pop_front(), rdata, exp_q.pop_front());
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int div);
      @(posedge clk); #1 rxd_drv = 1'b0;
      repeat (div) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         #1 rxd_drv = b[i];
         repeat (div) @(posedge clk);
      end
      #1 rxd_drv = stop_bit;
      repeat (div) @(posedge clk);
      #1 rxd_drv = 1'b1;
      repeat (2 * div) @(posedge clk);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0] frame;
      logic [5:0] d1_exp;
      rst = 1'b1; valid = 1'b0; address = '0; wdata = '0; wstrb = '0;
      rxd_drv = 1'b1; loopback = 1'b0;
`ifdef UART_RTS_CTS_EN
      cts = 1'b1;
`endif
      #1;
      check("rst_txd", 32'(txd), 32'd1);
      check("rst_ready", 32'(ready), 32'd0);
      check("rst_rdata", rdata, 32'd0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      bus_read("rst_txready", 3'd5, 32'd0);
      bus_read("rst_rxready", 3'd6, 32'd0);
      bus_read("rst_rxdata", 3'd7, 32'd0);

      // transmit 0x55 at DIV=4, with a dropped write mid-frame
      bus_write(3'd1, 32'd4);
      bus_write(3'd3, 32'd1);
      bus_read("txready_idle", 3'd5, 32'd1);
      frame = {1'b1, 8'h55, 1'b0};
      bus_write(3'd2, 32'h55);
      fork
         begin
            for (int i = 0; i < 40; i++) begin
               check($sformatf("tx55_c%0d", i), 32'(txd), 32'(frame[i / 4]));
               @(posedge clk); #1;
            end
         end
         begin
            repeat (10) @(posedge clk);
            bus_read("tx_busy", 3'd5, 32'd0);
            bus_write(3'd2, 32'hFF);
            bus_read("tx_busy2", 3'd5, 32'd0);
         end
      join
      bus_read("tx_done", 3'd5, 32'd1);
      for (int i = 0; i < 8; i++) begin
         check("tx_dropped", 32'(txd), 32'd1);
         @(posedge clk); #1;
      end

      // loopback 0xA3 at DIV=8
      loopback = 1'b1;
      bus_write(3'd1, 32'd8);
      bus_write(3'd4, 32'd1);
      bus_write(3'd2, 32'hA3);
      repeat (58) @(posedge clk);
      bus_read("lb_early", 3'd6, 32'd0);
      repeat (40) @(posedge clk);
      bus_read("lb_rxready", 3'd6, 32'd1);
      bus_read("lb_rxdata", 3'd7, 32'hA3);
      bus_read("lb_cleared", 3'd6, 32'd0);
      loopback = 1'b0;
      repeat (10) @(posedge clk);

      // framing error then a good frame
      send_frame(8'h3C, 1'b0, 8);
      bus_read("frame_err", 3'd6, 32'd0);
      send_frame(8'h81, 1'b1, 8);
      bus_read("rx81_ready", 3'd6, 32'd1);
      bus_read("rx81_data", 3'd7, 32'h81);

      // overrun keeps the newest byte
      send_frame(8'h11, 1'b1, 8);
      send_frame(8'h22, 1'b1, 8);
      bus_read("ovr_ready", 3'd6, 32'd1);
      bus_read("ovr_data", 3'd7, 32'h22);

      // one-cycle low glitch is rejected
      @(posedge clk); #1 rxd_drv = 1'b0;
      @(posedge clk); #1 rxd_drv = 1'b1;
      repeat (40) @(posedge clk);
      bus_read("glitch", 3'd6, 32'd0);

      // soft reset in the middle of data bit 3
      bus_write(3'd1, 32'd4);
      bus_write(3'd2, 32'h00);
      repeat (17) @(posedge clk); #1;
      check("sr_bit3_low", 32'(txd), 32'd0);
      bus_write(3'd0, 32'd1);
      check("sr_txd", 32'(txd), 32'd1);
      bus_read("sr_txready", 3'd5, 32'd1);
      check("sr_txd_hold", 32'(txd), 32'd1);

      // DIV=1 behaves as DIV=2
      bus_write(3'd1, 32'd1);
      d1_exp = 6'b001100;
      bus_write(3'd2, 32'h01);
      for (int i = 0; i < 6; i++) begin
         check($sformatf("div1_c%0d", i), 32'(txd), 32'(d1_exp[i]));
         @(posedge clk); #1;
      end
      repeat (24) @(posedge clk);
      bus_read("div1_done", 3'd5, 32'd1);

`ifdef UART_RTS_CTS_EN
      #1 cts = 1'b0;
      repeat (4) @(posedge clk);
      bus_read("cts_txready", 3'd5, 32'd0);
      bus_write(3'd2, 32'h5A);
      repeat (5) @(posedge clk); #1;
      check("cts_hold_txd", 32'(txd), 32'd1);
      check("rts_on", 32'(rts), 32'd1);
      cts = 1'b1;
      repeat (4) @(posedge clk);
      bus_read("cts_release", 3'd5, 32'd1);
      bus_write(3'd2, 32'h5A);
      check("cts_start", 32'(txd), 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
